// File: rtl/cache_line_ram_pkg.sv
// Shared widths and state encoding for the cache line data store.
package cache_line_ram_pkg;
    localparam int CL_DATA_W   = 32;
    localparam int CL_INDEX_W  = 7;
    localparam int CL_OFFSET_W = 2;
    localparam int CL_WORDS    = 2 ** CL_OFFSET_W;
    localparam int CL_BE_W     = CL_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_EVICT = 2'd2
    } line_state_e;
endpackage

// File: rtl/cache_line_ram_array.sv
// Line storage: one byte-enabled write port, one registered read port.
// A read that hits the word being written this cycle returns the merged new bytes.
module line_ram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        rd_word = mem[raddr];
        if (we && (waddr == raddr)) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) rd_word[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= rd_word;
    end
endmodule

// File: rtl/cache_line_ram.sv
// Cache data store with CPU access plus line FILL and EVICT burst engines.
//  state    | meaning
//  ST_IDLE  | CPU reads/writes served, waiting for a Start
//  ST_FILL  | writing FillData words 0..WORDS-1 into the captured line
//  ST_EVICT | streaming the captured line out over EvictValid/EvictReady
module cache_line_ram
    import cache_line_ram_pkg::*;
#(
    parameter int DATA_W   = CL_DATA_W,
    parameter int INDEX_W  = CL_INDEX_W,
    parameter int OFFSET_W = CL_OFFSET_W
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [INDEX_W-1:0]  Address,
    input  logic [OFFSET_W-1:0] WordSel,
    input  logic [DATA_W-1:0]   DataIn,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic                Write,
    input  logic                Read,
    output logic [DATA_W-1:0]   DataOut,
    output logic                DataValid,
    output logic                Busy,
    input  logic                FillStart,
    input  logic [INDEX_W-1:0]  FillIndex,
    input  logic [DATA_W-1:0]   FillData,
    input  logic                FillValid,
    output logic                FillDone,
    input  logic                EvictStart,
    input  logic [INDEX_W-1:0]  EvictIndex,
    output logic [DATA_W-1:0]   EvictData,
    output logic                EvictValid,
    input  logic                EvictReady,
    output logic                EvictDone
);
    localparam int BE_W   = DATA_W / 8;
    localparam int ADDR_W = INDEX_W + OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST = {OFFSET_W{1'b1}};

    line_state_e          state_q, state_d;
    logic [OFFSET_W-1:0]  cnt_q, cnt_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic                 fill_done_q, fill_done_d;
    logic                 evict_done_q, evict_done_d;
    logic                 cpu_rd_q, cpu_rd_d;
    logic [DATA_W-1:0]    hold_q;

    logic                 arr_we, arr_re;
    logic [ADDR_W-1:0]    arr_waddr, arr_raddr;
    logic [DATA_W-1:0]    arr_wdata, arr_rdata;
    logic [BE_W-1:0]      arr_be;

    line_ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
        .clk   (Clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .be    (arr_be),
        .re    (arr_re),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        index_d      = index_q;
        fill_done_d  = 1'b0;
        evict_done_d = 1'b0;
        cpu_rd_d     = 1'b0;
        arr_we       = 1'b0;
        arr_waddr    = {Address, WordSel};
        arr_wdata    = DataIn;
        arr_be       = ByteEn;
        arr_re       = 1'b0;
        arr_raddr    = {Address, WordSel};
        case (state_q)
            ST_IDLE: begin
                arr_we   = Write;
                arr_re   = Read;
                cpu_rd_d = Read;
                if (FillStart) begin
                    state_d = ST_FILL;
                    index_d = FillIndex;
                    cnt_d   = '0;
                end else if (EvictStart) begin
                    // Eviction needs the read port at the Start edge; a coincident CPU read is dropped.
                    state_d   = ST_EVICT;
                    index_d   = EvictIndex;
                    cnt_d     = '0;
                    cpu_rd_d  = 1'b0;
                    arr_re    = 1'b1;
                    arr_raddr = {EvictIndex, {OFFSET_W{1'b0}}};
                end
            end
            ST_FILL: begin
                if (FillValid) begin
                    arr_we    = 1'b1;
                    arr_waddr = {index_q, cnt_q};
                    arr_wdata = FillData;
                    arr_be    = '1;
                    cnt_d     = cnt_q + OFFSET_W'(1);
                    if (cnt_q == LAST) begin
                        state_d     = ST_IDLE;
                        fill_done_d = 1'b1;
                        cnt_d       = '0;
                    end
                end
            end
            ST_EVICT: begin
                if (EvictReady) begin
                    if (cnt_q == LAST) begin
                        state_d      = ST_IDLE;
                        evict_done_d = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d     = cnt_q + OFFSET_W'(1);
                        arr_re    = 1'b1;
                        arr_raddr = {index_q, cnt_d};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (Reset) arr_we = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            index_q      <= '0;
            fill_done_q  <= 1'b0;
            evict_done_q <= 1'b0;
            cpu_rd_q     <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            index_q      <= index_d;
            fill_done_q  <= fill_done_d;
            evict_done_q <= evict_done_d;
            cpu_rd_q     <= cpu_rd_d;
            if (cpu_rd_q) hold_q <= arr_rdata;
        end
    end

    // The read port is shared with eviction, so the last CPU read result is kept in hold_q.
    assign DataOut    = cpu_rd_q ? arr_rdata : hold_q;
    assign DataValid  = cpu_rd_q;
    assign Busy       = (state_q != ST_IDLE);
    assign FillDone   = fill_done_q;
    assign EvictValid = (state_q == ST_EVICT);
    assign EvictData  = (state_q == ST_EVICT) ? arr_rdata : '0;
    assign EvictDone  = evict_done_q;
endmodule
